// File: rtl/ctrl_pkg.sv
// Shared encodings for the OTTER multicycle control unit: opcodes, FSM states,
// ALU operation codes and the datapath mux-select enums.
package ctrl_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;

    typedef enum logic [3:0] {
        ST_FETCH, ST_DECODE, ST_EXEC_R, ST_EXEC_I, ST_LUI, ST_AUIPC,
        ST_JAL, ST_JALR, ST_BRANCH, ST_LOAD, ST_STORE, ST_TRAP
    } state_t;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b1000;
    localparam logic [3:0] ALU_SLL  = 4'b0001;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SRA  = 4'b1101;
    localparam logic [3:0] ALU_OR   = 4'b0110;
    localparam logic [3:0] ALU_AND  = 4'b0111;

    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} immed_sel_t;
    typedef enum logic [1:0] {A_PC, A_OLD_PC, A_RS1, A_ZERO} alu_a_sel_t;
    typedef enum logic [1:0] {B_RS2, B_IMMED, B_FOUR} alu_b_sel_t;
    typedef enum logic [1:0] {REG_PC, REG_ALU, REG_MEM} reg_sel_t;
    typedef enum logic {ADDR_PC, ADDR_ALU} addr_sel_t;

    // Which ALU decode rule applies: plain add, R-type or I-type arithmetic.
    typedef enum logic [1:0] {ALU_CLS_ADD, ALU_CLS_R, ALU_CLS_I} alu_cls_t;

endpackage

// File: rtl/alu_dec.sv
// ALU operation decode from the instruction class, funct3 and inst[30].
import ctrl_pkg::*;

module alu_dec (
    input  alu_cls_t   i_cls,
    input  logic [2:0] i_funct3,
    input  logic       i_bit30,
    output logic [3:0] o_alu_op
);

    always_comb begin
        o_alu_op = ALU_ADD;
        case (i_cls)
            ALU_CLS_R: o_alu_op = {i_bit30, i_funct3};
            // inst[30] is immediate data for everything except the shift-right pair
            ALU_CLS_I: o_alu_op = {(i_funct3 == 3'b101) & i_bit30, i_funct3};
            default:   o_alu_op = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/control_fsm.sv
// Multicycle OTTER sequencer: state register plus combinational control decode,
// including the memory request/ready handshake for fetch, load and store.
import ctrl_pkg::*;

module control_fsm (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] inst,
    input  logic        mem_ready,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic        pcUpdate,
    output logic        enBranch,
    output logic        irWrite,
    output logic        addrSrc,
    output logic [1:0]  regSrc,
    output logic        regWrite,
    output logic [2:0]  immedSrc,
    output logic [1:0]  aluSrcA,
    output logic [1:0]  aluSrcB,
    output logic [3:0]  aluOp,
    output logic        illegal
);

    state_t     r_state;
    state_t     w_next;
    logic       r_illegal;
    alu_cls_t   w_cls;
    logic [3:0] w_alu_op;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_FETCH;
            r_illegal <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_next == ST_TRAP) begin
                r_illegal <= 1'b1;
            end
        end
    end

    always_comb begin
        case (r_state)
            ST_EXEC_R: w_cls = ALU_CLS_R;
            ST_EXEC_I: w_cls = ALU_CLS_I;
            default:   w_cls = ALU_CLS_ADD;
        endcase
    end

    alu_dec u_alu_dec (
        .i_cls    (w_cls),
        .i_funct3 (inst[14:12]),
        .i_bit30  (inst[30]),
        .o_alu_op (w_alu_op)
    );

    always_comb begin
        w_next   = r_state;
        mem_rd   = 1'b0;
        mem_wr   = 1'b0;
        mem_size = 2'b00;
        pcUpdate = 1'b0;
        enBranch = 1'b0;
        irWrite  = 1'b0;
        addrSrc  = ADDR_PC;
        regSrc   = REG_PC;
        regWrite = 1'b0;
        immedSrc = IMM_I;
        aluSrcA  = A_PC;
        aluSrcB  = B_RS2;
        aluOp    = w_alu_op;
        illegal  = r_illegal;

        case (r_state)
            ST_FETCH: begin
                mem_rd   = 1'b1;
                mem_size = SIZE_WORD;
                aluSrcB  = B_FOUR;
                if (mem_ready) begin
                    irWrite  = 1'b1;
                    pcUpdate = 1'b1;
                    w_next   = ST_DECODE;
                end
            end
            ST_DECODE: begin
                case (inst[6:0])
                    OP_R:      w_next = ST_EXEC_R;
                    OP_I:      w_next = ST_EXEC_I;
                    OP_LUI:    w_next = ST_LUI;
                    OP_AUIPC:  w_next = ST_AUIPC;
                    OP_JAL:    w_next = ST_JAL;
                    OP_JALR:   w_next = ST_JALR;
                    OP_BRANCH: w_next = ST_BRANCH;
                    OP_LOAD:   w_next = ST_LOAD;
                    OP_STORE:  w_next = ST_STORE;
                    OP_FENCE:  w_next = ST_FETCH;
                    default:   w_next = ST_TRAP;
                endcase
            end
            ST_EXEC_R: begin
                aluSrcA  = A_RS1;
                regSrc   = REG_ALU;
                regWrite = 1'b1;
                w_next   = ST_FETCH;
            end
            ST_EXEC_I: begin
                aluSrcA  = A_RS1;
                aluSrcB  = B_IMMED;
                regSrc   = REG_ALU;
                regWrite = 1'b1;
                w_next   = ST_FETCH;
            end
            ST_LUI, ST_AUIPC: begin
                aluSrcA  = (r_state == ST_LUI) ? A_ZERO : A_OLD_PC;
                aluSrcB  = B_IMMED;
                immedSrc = IMM_U;
                regSrc   = REG_ALU;
                regWrite = 1'b1;
                w_next   = ST_FETCH;
            end
            // rd takes the PC register, which already holds the return address
            ST_JAL, ST_JALR: begin
                aluSrcA  = (r_state == ST_JAL) ? A_OLD_PC : A_RS1;
                aluSrcB  = B_IMMED;
                immedSrc = (r_state == ST_JAL) ? IMM_J : IMM_I;
                pcUpdate = 1'b1;
                regSrc   = REG_PC;
                regWrite = 1'b1;
                w_next   = ST_FETCH;
            end
            ST_BRANCH: begin
                aluSrcA  = A_OLD_PC;
                aluSrcB  = B_IMMED;
                immedSrc = IMM_B;
                enBranch = 1'b1;
                w_next   = ST_FETCH;
            end
            ST_LOAD: begin
                mem_rd   = 1'b1;
                mem_size = inst[13:12];
                addrSrc  = ADDR_ALU;
                aluSrcA  = A_RS1;
                aluSrcB  = B_IMMED;
                regSrc   = REG_MEM;
                if (mem_ready) begin
                    regWrite = 1'b1;
                    w_next   = ST_FETCH;
                end
            end
            ST_STORE: begin
                mem_wr   = 1'b1;
                mem_size = inst[13:12];
                addrSrc  = ADDR_ALU;
                aluSrcA  = A_RS1;
                aluSrcB  = B_IMMED;
                immedSrc = IMM_S;
                if (mem_ready) begin
                    w_next = ST_FETCH;
                end
            end
            ST_TRAP: begin
                w_next = ST_TRAP;
            end
            default: begin
                w_next = ST_FETCH;
            end
        endcase

        // Reset silences every control so an interrupted access cannot commit.
        if (rst) begin
            mem_rd   = 1'b0;
            mem_wr   = 1'b0;
            mem_size = 2'b00;
            pcUpdate = 1'b0;
            enBranch = 1'b0;
            irWrite  = 1'b0;
            addrSrc  = ADDR_PC;
            regSrc   = REG_PC;
            regWrite = 1'b0;
            immedSrc = IMM_I;
            aluSrcA  = A_PC;
            aluSrcB  = B_RS2;
            aluOp    = ALU_ADD;
            illegal  = 1'b0;
        end
    end

endmodule

// File: tb/tb_control_fsm.sv
// Bench for control_fsm: directed cycle table, hand-written corner sequences,
// and randomized instruction streams against a per-instruction reference model.
module tb_control_fsm;

    typedef struct packed {
        logic       rd;
        logic       wr;
        logic [1:0] size;
        logic       pcu;
        logic       enb;
        logic       irw;
        logic       addr;
        logic [1:0] rsrc;
        logic       rw;
        logic [2:0] imm;
        logic [1:0] a;
        logic [1:0] b;
        logic [3:0] op;
        logic       ill;
    } out_t;

    typedef struct {
        logic        r;
        logic        rdy;
        logic [31:0] in;
        out_t        exp;
        string       nm;
    } vec_t;

    logic        clk;
    logic        rst;
    logic [31:0] inst;
    logic        mem_ready;
    logic        mem_rd, mem_wr, pcUpdate, enBranch, irWrite, addrSrc, regWrite, illegal;
    logic [1:0]  mem_size, regSrc, aluSrcA, aluSrcB;
    logic [2:0]  immedSrc;
    logic [3:0]  aluOp;
    out_t        got;

    int checks = 0;
    int errors = 0;
    int cycno  = 0;

    control_fsm dut (
        .clk       (clk),
        .rst       (rst),
        .inst      (inst),
        .mem_ready (mem_ready),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .mem_size  (mem_size),
        .pcUpdate  (pcUpdate),
        .enBranch  (enBranch),
        .irWrite   (irWrite),
        .addrSrc   (addrSrc),
        .regSrc    (regSrc),
        .regWrite  (regWrite),
        .immedSrc  (immedSrc),
        .aluSrcA   (aluSrcA),
        .aluSrcB   (aluSrcB),
        .aluOp     (aluOp),
        .illegal   (illegal)
    );

    assign got = '{rd: mem_rd, wr: mem_wr, size: mem_size, pcu: pcUpdate, enb: enBranch,
                   irw: irWrite, addr: addrSrc, rsrc: regSrc, rw: regWrite, imm: immedSrc,
                   a: aluSrcA, b: aluSrcB, op: aluOp, ill: illegal};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic out_t pk(int rd, int wr, int size, int pcu, int enb, int irw, int addr,
                                int rsrc, int rw, int imm, int a, int b, int op, int ill);
        out_t o;
        o.rd = 1'(rd);   o.wr = 1'(wr);     o.size = 2'(size); o.pcu = 1'(pcu);
        o.enb = 1'(enb); o.irw = 1'(irw);   o.addr = 1'(addr); o.rsrc = 2'(rsrc);
        o.rw = 1'(rw);   o.imm = 3'(imm);   o.a = 2'(a);       o.b = 2'(b);
        o.op = 4'(op);   o.ill = 1'(ill);
        return o;
    endfunction

    function automatic vec_t mkv(logic r, logic rdy, logic [31:0] in, out_t exp, string nm);
        vec_t v;
        v.r = r; v.rdy = rdy; v.in = in; v.exp = exp; v.nm = nm;
        return v;
    endfunction

    // Reference: controls expected in the fetch cycle and in the execute cycle of an instruction.
    function automatic out_t m_fetch(logic rdy);
        return pk(1, 0, 2, int'(rdy), 0, int'(rdy), 0, 0, 0, 0, 0, 2, 0, 0);
    endfunction

    function automatic out_t m_exec(logic [31:0] in, logic rdy);
        int f3 = int'(in[14:12]);
        int sz = int'(in[13:12]);
        int b30 = int'(in[30]);
        case (in[6:0])
            7'h33: return pk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 2, 0, b30 * 8 + f3, 0);
            7'h13: return pk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 2, 1, ((f3 == 5) ? b30 * 8 : 0) + f3, 0);
            7'h37: return pk(0, 0, 0, 0, 0, 0, 0, 1, 1, 3, 3, 1, 0, 0);
            7'h17: return pk(0, 0, 0, 0, 0, 0, 0, 1, 1, 3, 1, 1, 0, 0);
            7'h6F: return pk(0, 0, 0, 1, 0, 0, 0, 0, 1, 4, 1, 1, 0, 0);
            7'h67: return pk(0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 2, 1, 0, 0);
            7'h63: return pk(0, 0, 0, 0, 1, 0, 0, 0, 0, 2, 1, 1, 0, 0);
            7'h03: return pk(1, 0, sz, 0, 0, 0, 1, 2, int'(rdy), 0, 2, 1, 0, 0);
            7'h23: return pk(0, 1, sz, 0, 0, 0, 1, 0, 0, 1, 2, 1, 0, 0);
            default: return pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        endcase
    endfunction

    task automatic cyc(input logic r, input logic rdy, input logic [31:0] in,
                       input out_t exp, input string nm);
        @(posedge clk);
        #1;
        rst = r;
        mem_ready = rdy;
        inst = in;
        @(negedge clk);
        cycno++;
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d inst %h: got %h expected %h", nm, cycno, in, got, exp);
        end
    endtask

    task automatic run_instr(input logic [31:0] in, input int wf, input int wm);
        logic [6:0] op;
        logic       r1;
        op = in[6:0];
        for (int i = 0; i < wf; i++) cyc(0, 0, in, m_fetch(0), "fetch_wait");
        cyc(0, 1, in, m_fetch(1), "fetch_done");
        cyc(0, 1'($urandom_range(0, 1)), in, '0, "decode");
        if (op == 7'h0F) return;
        if (op == 7'h03 || op == 7'h23) begin
            for (int i = 0; i < wm; i++) cyc(0, 0, in, m_exec(in, 0), "mem_wait");
            cyc(0, 1, in, m_exec(in, 1), "mem_done");
        end else if (op inside {7'h33, 7'h13, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h63}) begin
            r1 = 1'($urandom_range(0, 1));
            cyc(0, r1, in, m_exec(in, r1), "exec");
        end else begin
            cyc(0, 1'($urandom_range(0, 1)), in, m_exec(in, 0), "trap");
            cyc(0, 1'($urandom_range(0, 1)), in, m_exec(in, 0), "trap_hold");
            cyc(1, 1'($urandom_range(0, 1)), in, '0, "trap_reset");
        end
    endtask

    vec_t        tbl[$];
    out_t        o_fw, o_fr, o_z;
    int          k;
    logic [31:0] rin;
    logic [6:0]  ops[12];

    initial begin
        rst = 1'b1;
        mem_ready = 1'b0;
        inst = 32'h0;
        o_fw = pk(1, 0, 2, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 0);
        o_fr = pk(1, 0, 2, 1, 0, 1, 0, 0, 0, 0, 0, 2, 0, 0);
        o_z  = '0;

        tbl.push_back(mkv(1, 1, 32'h00310133, o_z, "reset_zero"));
        tbl.push_back(mkv(0, 1, 32'h00310133, o_fr, "add_fetch"));
        tbl.push_back(mkv(0, 1, 32'h00310133, o_z, "add_decode"));
        tbl.push_back(mkv(0, 1, 32'h00310133, pk(0,0,0,0,0,0,0,1,1,0,2,0,0,0), "add_exec"));
        tbl.push_back(mkv(0, 0, 32'h4020D093, o_fw, "fetch_wait1"));
        tbl.push_back(mkv(0, 0, 32'h4020D093, o_fw, "fetch_wait2"));
        tbl.push_back(mkv(0, 1, 32'h4020D093, o_fr, "fetch_wait_done"));
        tbl.push_back(mkv(0, 1, 32'h4020D093, o_z, "srai_decode"));
        tbl.push_back(mkv(0, 1, 32'h4020D093, pk(0,0,0,0,0,0,0,1,1,0,2,1,13,0), "srai_exec"));
        tbl.push_back(mkv(0, 1, 32'h0020E093, o_fr, "ori_fetch"));
        tbl.push_back(mkv(0, 1, 32'h0020E093, o_z, "ori_decode"));
        tbl.push_back(mkv(0, 1, 32'h0020E093, pk(0,0,0,0,0,0,0,1,1,0,2,1,6,0), "ori_exec"));
        tbl.push_back(mkv(0, 1, 32'h0040A183, o_fr, "lw_fetch"));
        tbl.push_back(mkv(0, 1, 32'h0040A183, o_z, "lw_decode"));
        tbl.push_back(mkv(0, 0, 32'h0040A183, pk(1,0,2,0,0,0,1,2,0,0,2,1,0,0), "lw_wait"));
        tbl.push_back(mkv(0, 1, 32'h0040A183, pk(1,0,2,0,0,0,1,2,1,0,2,1,0,0), "lw_done"));
        tbl.push_back(mkv(0, 1, 32'h0030A223, o_fr, "sw_fetch"));
        tbl.push_back(mkv(0, 1, 32'h0030A223, o_z, "sw_decode"));
        tbl.push_back(mkv(0, 1, 32'h0030A223, pk(0,1,2,0,0,0,1,0,0,1,2,1,0,0), "sw_done"));
        tbl.push_back(mkv(0, 1, 32'h008000EF, o_fr, "jal_fetch"));
        tbl.push_back(mkv(0, 1, 32'h008000EF, o_z, "jal_decode"));
        tbl.push_back(mkv(0, 0, 32'h008000EF, pk(0,0,0,1,0,0,0,0,1,4,1,1,0,0), "jal_exec"));
        tbl.push_back(mkv(0, 1, 32'h00208463, o_fr, "beq_fetch"));
        tbl.push_back(mkv(0, 1, 32'h00208463, o_z, "beq_decode"));
        tbl.push_back(mkv(0, 1, 32'h00208463, pk(0,0,0,0,1,0,0,0,0,2,1,1,0,0), "beq_exec"));
        tbl.push_back(mkv(0, 1, 32'h00000073, o_fr, "ecall_fetch"));
        tbl.push_back(mkv(0, 1, 32'h00000073, o_z, "ecall_decode"));
        tbl.push_back(mkv(0, 1, 32'h00000073, pk(0,0,0,0,0,0,0,0,0,0,0,0,0,1), "trap"));
        tbl.push_back(mkv(0, 1, 32'h00310133, pk(0,0,0,0,0,0,0,0,0,0,0,0,0,1), "trap_sticky"));
        tbl.push_back(mkv(1, 1, 32'h00310133, o_z, "trap_reset"));
        tbl.push_back(mkv(0, 0, 32'h00310133, o_fw, "post_trap_fetch"));

        foreach (tbl[i]) cyc(tbl[i].r, tbl[i].rdy, tbl[i].in, tbl[i].exp, tbl[i].nm);

        // Reset during a load wait must kill the access without a register write.
        cyc(0, 1, 32'h0040A183, o_fr, "abort_fetch");
        cyc(0, 0, 32'h0040A183, o_z, "abort_decode");
        cyc(0, 0, 32'h0040A183, pk(1,0,2,0,0,0,1,2,0,0,2,1,0,0), "abort_wait");
        cyc(1, 1, 32'h0040A183, o_z, "abort_reset");
        cyc(0, 0, 32'h0040A183, o_fw, "abort_refetch");

        // FENCE: fetch, decode, then straight back to fetch.
        cyc(0, 1, 32'h0000000F, o_fr, "fence_fetch");
        cyc(0, 1, 32'h0000000F, o_z, "fence_decode");
        cyc(0, 0, 32'h0000000F, o_fw, "fence_refetch");
        cyc(0, 1, 32'h0000000F, o_fr, "fence_fetch2");
        cyc(0, 1, 32'h0000000F, o_z, "fence_decode2");

        ops = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h0F, 7'h73, 7'h7F};
        for (int n = 0; n < 200; n++) begin
            k = $urandom_range(0, 11);
            rin = $urandom;
            rin[6:0] = ops[k];
            run_instr(rin, $urandom_range(0, 2), $urandom_range(0, 2));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
